// File: rtl/ram_lsu_bridge.sv
// ram_lsu_bridge: load/store bridge from the core memory stage to a word-wide data RAM.
// The RAM has a synchronous write, a combinational read and no byte enables.
// Byte and half stores use read-modify-write. Loads are sign- or zero-extended.
// Optional macro RAM_BRIDGE_ERR_EN enables rejection of misaligned, illegal-size and
// out-of-range requests. Without it, addresses are forced to natural alignment,
// the word index wraps modulo DEPTH, size 11 behaves as a word access and rsp_err_o is 0.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | RAM read of the addressed word; extract and extend the lane
// RMW_RD | RAM read of the old word; merge the store lane into it
// WRITE  | ram_wen_o high for one cycle
// RESP   | rsp_valid_o pulse
module ram_lsu_bridge #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_wen_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  size_eff;
    logic [31:0] addr_eff;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept     = req_valid_i & req_ready_o;
    assign ram_addr_o = {addr_q[31:2], 2'b00};

`ifdef RAM_BRIDGE_ERR_EN
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    // Classify the incoming request; the address is kept unmodified.
    always_comb begin
        size_eff = req_size_i;
        addr_eff = req_addr_i;
        req_err  = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b01) & req_addr_i[0])
                 | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00))
                 | ({2'b00, req_addr_i[31:2]} >= DEPTH_W);
    end
`else
    logic [29:0] widx;
    logic [1:0]  lane;

    // Without checks, force natural alignment and wrap the word index into the RAM.
    always_comb begin
        req_err  = 1'b0;
        size_eff = (req_size_i == 2'b11) ? 2'b10 : req_size_i;
        widx     = req_addr_i[31:2] % 30'(DEPTH);
        case (size_eff)
            2'b00:   lane = req_addr_i[1:0];
            2'b01:   lane = {req_addr_i[1], 1'b0};
            default: lane = 2'b00;
        endcase
        addr_eff = {widx, lane};
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)               state_next = RESP;
                    else if (!req_we_i)        state_next = LOAD;
                    else if (size_eff == 2'b10) state_next = WRITE;
                    else                       state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM-decoded outputs; reset gates ready and write enable immediately.
    always_comb begin
        req_ready_o = (state == IDLE) & rstn;
        ram_wen_o   = (state == WRITE) & rstn;
        rsp_valid_o = (state == RESP);
    end

    // Extract and extend the addressed lane from the RAM read data.
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] hw;
        shifted = ram_rdata_i >> {addr_q[1:0], 3'b000};
        hw      = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~uns_q & hw[15]}}, hw};
            default: load_val = ram_rdata_i;
        endcase
    end

    // Insert the store lane into the old RAM word, keeping every other byte.
    always_comb begin
        merged = wdata_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged = {ram_rdata_i[31:8], wdata_q[7:0]};
                2'b01:   merged = {ram_rdata_i[31:16], wdata_q[7:0], ram_rdata_i[7:0]};
                2'b10:   merged = {ram_rdata_i[31:24], wdata_q[7:0], ram_rdata_i[15:0]};
                default: merged = {wdata_q[7:0], ram_rdata_i[23:0]};
            endcase
        end else if (size_q == 2'b01) begin
            merged = addr_q[1] ? {wdata_q[15:0], ram_rdata_i[15:0]}
                               : {ram_rdata_i[31:16], wdata_q[15:0]};
        end
    end

    // Request capture, write data and response registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            ram_wdata_o <= 32'h0;
        end else begin
            if (accept) begin
                size_q  <= size_eff;
                uns_q   <= req_unsigned_i;
                addr_q  <= addr_eff;
                wdata_q <= req_wdata_i;
                if (req_err) begin
                    rsp_rdata_o <= 32'h0;
                    rsp_err_o   <= 1'b1;
                end else if (req_we_i && size_eff == 2'b10) begin
                    ram_wdata_o <= req_wdata_i;
                end
            end
            case (state)
                LOAD: begin
                    rsp_rdata_o <= load_val;
                    rsp_err_o   <= 1'b0;
                end
                RMW_RD: ram_wdata_o <= merged;
                WRITE: begin
                    rsp_rdata_o <= 32'h0;
                    rsp_err_o   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Testbench for ram_lsu_bridge: RAM model plus an arithmetic reference memory model.
module tb_ram_lsu_bridge;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] dut_mem [DEPTH] = '{default: 32'h0};
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] last_rd = 32'h0;
    logic        last_err = 1'b0;

    ram_lsu_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .ram_wen_o(ram_wen), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = dut_mem[ram_addr[13:2]];

    always @(posedge clk) begin
        if (ram_wen) dut_mem[ram_addr[13:2]] <= ram_wdata;
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic        err;
        int          s, idx, off, exp_lat, exp_wen, lat, wens;
        logic [31:0] w, v, mask, exp_rd;
        logic        got;
        s   = int'(size);
        idx = int'((addr >> 2) % 32'(DEPTH));
        off = int'(addr[1:0]);
`ifdef RAM_BRIDGE_ERR_EN
        err = (s == 3) || (s == 1 && addr[0]) || (s == 2 && addr[1:0] != 2'b00)
              || ((addr >> 2) >= 32'(DEPTH));
`else
        err = 1'b0;
        if (s == 3) s = 2;
        if (s == 1) off = off - (off % 2);
        if (s == 2) off = 0;
`endif
        w = ref_mem[idx];
        exp_rd = 32'h0;
        exp_wen = 0;
        if (err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            if (s == 0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
            end else if (s == 1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            exp_rd = v;
        end else begin
            exp_lat = (s == 2) ? 2 : 3;
            exp_wen = 1;
            if (s == 2) mask = 32'hFFFFFFFF;
            else if (s == 1) mask = 32'hFFFF << (8 * off);
            else mask = 32'hFF << (8 * off);
            ref_mem[idx] = (w & ~mask) | ((wdata << (8 * off)) & mask);
        end

        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL %s idle: ready=%b rsp_valid=%b, required ready=1 rsp_valid=0",
                     tag, req_ready, rsp_valid);
        else if (rsp_rdata !== last_rd || rsp_err !== last_err)
            $display("FAIL %s hold: rdata=%h err=%b, required %h %b", tag, rsp_rdata, rsp_err,
                     last_rd, last_err);
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== last_rd || rsp_err !== last_err)
            n_miss++;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; wens = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (ram_wen) wens++;
            if (rsp_valid) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_miss++;
            $display("FAIL %s timeout: no rsp_valid within %0d cycles, required at %0d", tag, lat, exp_lat);
        end else begin
            if (lat != exp_lat || wens != exp_wen || req_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL %s timing: lat=%0d wen=%0d ready=%b, required lat=%0d wen=%0d ready=0",
                         tag, lat, wens, req_ready, exp_lat, exp_wen);
            end
            n_vec++;
            if (rsp_rdata !== exp_rd || rsp_err !== err) begin
                n_miss++;
                $display("FAIL %s rsp: rdata=%h err=%b, required rdata=%h err=%b",
                         tag, rsp_rdata, rsp_err, exp_rd, err);
            end
        end
        n_vec++;
        if (dut_mem[idx] !== ref_mem[idx]) begin
            n_miss++;
            $display("FAIL %s ram[%0d]: got %h, required %h", tag, idx, dut_mem[idx], ref_mem[idx]);
        end
        last_rd = exp_rd;
        last_err = err;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || ram_wen !== 1'b0 ||
            ram_addr !== 32'h0 || ram_wdata !== 32'h0 || req_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL %s: valid=%b rdata=%h err=%b wen=%b addr=%h wdata=%h ready=%b, required all 0",
                     tag, rsp_valid, rsp_rdata, rsp_err, ram_wen, ram_addr, ram_wdata, req_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        rstn = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_release: ready=%b, required 1", req_ready);
        end
        last_rd = 32'h0; last_err = 1'b0;
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_10");
    endtask

    task automatic test_byte_rmw();
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h55, "sb_12");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_10_after_sb");
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "lb_12");
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb_13");
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu_13");
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF8001, "sh_16");
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "lw_14");
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, "lh_16");
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, "lhu_16");
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, "lw_11");
        do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'hABCD, "sh_21");
        do_req(1'b1, 2'b11, 1'b0, 32'h24, 32'h11223344, "size_11_store");
        do_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'h99999999, "sw_4000");
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "lw_0_after_errs");
    endtask

    task automatic test_reset_midop();
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, "sw_20");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h21; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_vec++;
        if (ram_wen !== 1'b0 || req_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL midop_rst_assert: wen=%b ready=%b, required 0 0", ram_wen, req_ready);
        end
        @(negedge clk);
        check_reset_outputs("midop_reset_state");
        rstn = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || ram_wen !== 1'b0) begin
            n_miss++;
            $display("FAIL midop_release: ready=%b wen=%b, required 1 0", req_ready, ram_wen);
        end
        @(negedge clk);
        n_vec++;
        if (dut_mem[8] !== ref_mem[8]) begin
            n_miss++;
            $display("FAIL midop_ram: got %h, required %h", dut_mem[8], ref_mem[8]);
        end
        last_rd = 32'h0; last_err = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, "random");
        end
    endtask

    task automatic test_ram_final();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        n_vec++;
        if (bad != 0) begin
            n_miss++;
            $display("FAIL ram_final: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_misaligned();
        test_reset_midop();
        test_random();
        test_ram_final();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
